// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared processor types: datapath width, ALU func codes, shifter state/kind
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    SLL, SLLI, SLR, SLRI, SRA, SRAI, ROL, ROLI, ROR, RORI,
    ADD, SUB, AND_OP, OR_OP, XOR_OP, SLT
  } func_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} shift_state_t;

  typedef enum logic [1:0] {SH_LOGIC, SH_ARITH, SH_ROT} shift_kind_t;

endpackage

// File: rtl/alu_shift_iter_if.sv
// rtl/alu_shift_iter_if.sv - request/response bundle between issue stage, shifter and result mux
interface alu_shift_iter_if
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int IMM_WIDTH  = 6
);
  logic                  op_valid_i;
  logic                  op_ready_o;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  func_t                 func_i;
  logic [IMM_WIDTH-1:0]  imm_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  illegal_o;

  modport master (
    output op_valid_i, rs1_data_i, rs2_data_i, func_i, imm_i, res_ready_i,
    input  op_ready_o, res_valid_o, result_o, illegal_o
  );

  modport slave (
    input  op_valid_i, rs1_data_i, rs2_data_i, func_i, imm_i, res_ready_i,
    output op_ready_o, res_valid_o, result_o, illegal_o
  );
endinterface

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational shift/rotate by 0..STEP_BITS positions
module alu_shift_step
  import simple_processor_pkg::*;
#(
  parameter int  DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int  STEP_BITS  = 4,
  localparam int AMT_W      = $clog2(STEP_BITS + 1)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  shift_kind_t           kind_i,
  input  logic                  right_i,
  input  logic [AMT_W-1:0]      amt_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0]   fill;
  logic [2*DATA_WIDTH-1:0] wide;

  // Concatenate the fill pattern beside the data so one shifter covers all kinds
  always_comb begin
    fill = '0;
    if (kind_i == SH_ROT) begin
      fill = data_i;
    end else if (kind_i == SH_ARITH && right_i) begin
      fill = {DATA_WIDTH{data_i[DATA_WIDTH-1]}};
    end
    if (right_i) begin
      wide   = {fill, data_i} >> amt_i;
      data_o = wide[DATA_WIDTH-1:0];
    end else begin
      wide   = {data_i, fill} << amt_i;
      data_o = wide[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end
endmodule

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - multi-cycle shift/rotate unit; ALU_SHIFT_ITER_PERF_EN adds a busy-cycle counter
module alu_shift_iter
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int STEP_BITS  = 4,
  parameter int IMM_WIDTH  = 6
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                flush_i,
  alu_shift_iter_if.slave     bus,
  output logic [31:0]         busy_cycles_o
);
  localparam int REM_W  = $clog2(DATA_WIDTH + 1);
  localparam int SH_W   = $clog2(DATA_WIDTH);
  localparam int STEP_W = $clog2(STEP_BITS + 1);
  localparam int AMT_W  = (DATA_WIDTH > IMM_WIDTH) ? DATA_WIDTH : IMM_WIDTH;

  shift_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  shift_kind_t           kind_q, kind_d;
  logic                  right_q, right_d;
  logic                  illegal_q, illegal_d;

  shift_kind_t           dec_kind;
  logic                  dec_right, dec_imm, dec_legal;
  logic [AMT_W-1:0]      amt;
  logic [REM_W-1:0]      eff;
  logic                  last_step;
  logic [STEP_W-1:0]     step_amt;
  logic [DATA_WIDTH-1:0] step_out;

  always_comb begin
    dec_kind  = SH_LOGIC;
    dec_right = 1'b0;
    dec_imm   = 1'b0;
    dec_legal = 1'b1;
    case (bus.func_i)
      SLL:     ;
      SLLI:    dec_imm = 1'b1;
      SLR:     dec_right = 1'b1;
      SLRI:    begin dec_right = 1'b1; dec_imm = 1'b1; end
      SRA:     begin dec_kind = SH_ARITH; dec_right = 1'b1; end
      SRAI:    begin dec_kind = SH_ARITH; dec_right = 1'b1; dec_imm = 1'b1; end
      ROL:     dec_kind = SH_ROT;
      ROLI:    begin dec_kind = SH_ROT; dec_imm = 1'b1; end
      ROR:     begin dec_kind = SH_ROT; dec_right = 1'b1; end
      RORI:    begin dec_kind = SH_ROT; dec_right = 1'b1; dec_imm = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign amt = dec_imm ? AMT_W'(bus.imm_i) : AMT_W'(bus.rs2_data_i);

  // Logical/arithmetic amounts saturate at the width; rotates wrap
  always_comb begin
    eff = REM_W'(amt[SH_W-1:0]);
    if (!dec_legal) begin
      eff = '0;
    end else if (dec_kind != SH_ROT && amt >= AMT_W'(DATA_WIDTH)) begin
      eff = REM_W'(DATA_WIDTH);
    end
  end

  assign last_step = (rem_q <= REM_W'(STEP_BITS));
  assign step_amt  = last_step ? STEP_W'(rem_q) : STEP_W'(STEP_BITS);

  alu_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP_BITS  (STEP_BITS)
  ) u_step (
    .data_i  (work_q),
    .kind_i  (kind_q),
    .right_i (right_q),
    .amt_i   (step_amt),
    .data_o  (step_out)
  );

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rem_d     = rem_q;
    kind_d    = kind_q;
    right_d   = right_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid_i) begin
          work_d    = bus.rs1_data_i;
          kind_d    = dec_kind;
          right_d   = dec_right;
          illegal_d = !dec_legal;
          rem_d     = eff;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        work_d = step_out;
        if (last_step) begin
          rem_d   = '0;
          state_d = DONE;
        end else begin
          rem_d = rem_q - REM_W'(STEP_BITS);
        end
      end
      DONE: begin
        if (bus.res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      work_q    <= '0;
      rem_q     <= '0;
      kind_q    <= SH_LOGIC;
      right_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      kind_q    <= kind_d;
      right_q   <= right_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.op_ready_o  = (state_q == IDLE);
  assign bus.res_valid_o = (state_q == DONE);
  assign bus.result_o    = (state_q == DONE) ? work_q : '0;
  assign bus.illegal_o   = (state_q == DONE) && illegal_q;

`ifdef ALU_SHIFT_ITER_PERF_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (state_q == BUSY && busy_cnt_q != '1) begin
      busy_cnt_d = busy_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cycles_o = busy_cnt_q;
`else
  assign busy_cycles_o = '0;
`endif
endmodule

// File: tb/tb_alu_shift_iter.sv
// tb/tb_alu_shift_iter.sv - self-checking bench for alu_shift_iter with a behavioural reference model
module tb_alu_shift_iter;
  import simple_processor_pkg::*;

  localparam int DW   = 32;
  localparam int STEP = 4;
  localparam int IW   = 6;

  logic        clk    = 1'b0;
  logic        arst_n = 1'b0;
  logic        flush  = 1'b0;
  logic [31:0] busy_cycles;

  always #5 clk = ~clk;

  alu_shift_iter_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

  alu_shift_iter #(.DATA_WIDTH(DW), .STEP_BITS(STEP), .IMM_WIDTH(IW)) dut (
    .clk_i         (clk),
    .arst_ni       (arst_n),
    .flush_i       (flush),
    .bus           (bus),
    .busy_cycles_o (busy_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: shift semantics from plain arithmetic on the full amount
  function automatic void ref_model(input func_t f, input logic [31:0] a, input logic [31:0] b,
                                    input logic [5:0] imm, output logic [31:0] r,
                                    output bit ill, output int lat);
    longint unsigned amt;
    int eff;
    int n;
    amt = (f inside {SLLI, SLRI, SRAI, ROLI, RORI}) ? {58'd0, imm} : {32'd0, b};
    eff = (amt >= 64'd32) ? 32 : int'(amt);
    n   = int'(amt % 64'd32);
    ill = 1'b0;
    case (f)
      SLL, SLLI: r = (amt >= 64'd32) ? 32'd0 : a << eff;
      SLR, SLRI: r = (amt >= 64'd32) ? 32'd0 : a >> eff;
      SRA, SRAI: r = (amt >= 64'd32) ? {32{a[31]}} : 32'($signed(a) >>> eff);
      ROL, ROLI: begin r = (a << n) | (a >> (32 - n)); eff = n; end
      ROR, RORI: begin r = (a >> n) | (a << (32 - n)); eff = n; end
      default:   begin r = a; ill = 1'b1; eff = 0; end
    endcase
    lat = (eff == 0) ? 1 : (eff + STEP - 1) / STEP;
  endfunction

  bit              m_flight = 1'b0;
  int              m_cyc = 0;
  int              m_lat = 0;
  logic [31:0]     m_res = '0;
  bit              m_ill = 1'b0;
  longint unsigned m_busy = 0;

  // Single compare process: checks every cycle against the model, then advances it
  always @(negedge clk) begin
    bit exp_valid;
    logic [31:0] exp_busy;
    if (!arst_n) begin
      check("rst_op_ready", 32'(bus.op_ready_o), 32'd1);
      check("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
      check("rst_result", bus.result_o, 32'd0);
      check("rst_illegal", 32'(bus.illegal_o), 32'd0);
      check("rst_busy_cycles", busy_cycles, 32'd0);
      m_flight = 1'b0;
      m_busy   = 0;
    end else begin
      exp_valid = m_flight && (m_cyc >= m_lat);
`ifdef ALU_SHIFT_ITER_PERF_EN
      exp_busy = (m_busy > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_busy[31:0];
`else
      exp_busy = 32'd0;
`endif
      check("op_ready", 32'(bus.op_ready_o), 32'(!m_flight));
      check("res_valid", 32'(bus.res_valid_o), 32'(exp_valid));
      check("busy_cycles", busy_cycles, exp_busy);
      if (exp_valid) begin
        check("result", bus.result_o, m_res);
        check("illegal", 32'(bus.illegal_o), 32'(m_ill));
      end
      if (m_flight && !exp_valid) m_busy++;
      if (flush) begin
        m_flight = 1'b0;
      end else if (!m_flight) begin
        if (bus.op_valid_i) begin
          ref_model(bus.func_i, bus.rs1_data_i, bus.rs2_data_i, bus.imm_i, m_res, m_ill, m_lat);
          m_flight = 1'b1;
          m_cyc    = 0;
        end
      end else if (exp_valid) begin
        if (bus.res_ready_i) m_flight = 1'b0;
      end else begin
        m_cyc++;
      end
    end
  end

  task automatic issue(input func_t f, input logic [31:0] a, input logic [31:0] b, input logic [5:0] imm);
    int t = 0;
    bus.func_i     = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.imm_i      = imm;
    bus.op_valid_i = 1'b1;
    while (!bus.op_ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_wait_ready", 32'(bus.op_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
  endtask

  task automatic collect(output int lat, output logic [31:0] res, output bit ill, input int hold);
    lat = 0;
    while (!bus.res_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("res_valid_timeout", 32'(bus.res_valid_o), 32'd1);
    res = bus.result_o;
    ill = bus.illegal_o;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check("hold_result_stable", bus.result_o, res);
      check("hold_op_ready_low", 32'(bus.op_ready_o), 32'd0);
    end
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
  endtask

  task automatic directed(input string name, input func_t f, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] imm, input logic [31:0] exp_res,
                          input bit exp_ill, input int exp_lat, input int hold);
    int lat;
    logic [31:0] res;
    bit ill;
    issue(f, a, b, imm);
    collect(lat, res, ill, hold);
    check({name, "_result"}, res, exp_res);
    check({name, "_illegal"}, 32'(ill), 32'(exp_ill));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int valid_seen;
    int lat;
    logic [31:0] res;
    bit ill;
    bus.op_valid_i  = 1'b0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.func_i      = SLL;
    bus.imm_i       = '0;
    bus.res_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_op_ready", 32'(bus.op_ready_o), 32'd1);
    check("reset_result", bus.result_o, 32'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    directed("sra_sign",   SRA,  32'h8000_0000, 32'd4,  6'd0,  32'hF800_0000, 1'b0, 1, 0);
    directed("ror_wrap",   ROR,  32'h0000_0001, 32'd33, 6'd0,  32'h8000_0000, 1'b0, 1, 0);
    directed("roli_zero",  ROLI, 32'h1234_5678, 32'd0,  6'd0,  32'h1234_5678, 1'b0, 1, 0);
    directed("sll_over",   SLL,  32'hFFFF_FFFF, 32'd40, 6'd0,  32'h0000_0000, 1'b0, 8, 0);
    directed("slli_zext",  SLLI, 32'hFFFF_FFFF, 32'd0,  6'h3F, 32'h0000_0000, 1'b0, 8, 0);
    directed("slr_hold",   SLR,  32'hF000_0000, 32'd10, 6'd0,  32'h003C_0000, 1'b0, 3, 5);
    directed("illegal_op", ADD,  32'hDEAD_BEEF, 32'd7,  6'd5,  32'hDEAD_BEEF, 1'b1, 1, 0);
    directed("rol_mid",    ROL,  32'h8000_0001, 32'd5,  6'd0,  32'h0000_0030, 1'b0, 2, 1);

    issue(SLL, 32'h0000_FFFF, 32'd20, 6'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_op_ready", 32'(bus.op_ready_o), 32'd1);
    valid_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.res_valid_o) valid_seen++;
    end
    check("flush_no_result", 32'(valid_seen), 32'd0);

    bus.func_i     = SLL;
    bus.op_valid_i = 1'b1;
    flush          = 1'b1;
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
    flush          = 1'b0;
    check("flush_blocks_accept", 32'(bus.op_ready_o), 32'd1);

    directed("srai_after_flush", SRAI, 32'h8000_0000, 32'd0, 6'd31, 32'hFFFF_FFFF, 1'b0, 8, 0);

    issue(SLR, 32'hF000_0000, 32'd10, 6'd0);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    check("arst_op_ready", 32'(bus.op_ready_o), 32'd1);
    check("arst_res_valid", 32'(bus.res_valid_o), 32'd0);
    check("arst_result", bus.result_o, 32'd0);
    check("arst_busy_cycles", busy_cycles, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      func_t f;
      logic [31:0] b;
      f = func_t'(4'($urandom_range(0, 15)));
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
      issue(f, $urandom, b, 6'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end else begin
        collect(lat, res, ill, int'($urandom_range(0, 3)));
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
